// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-high segment
// patterns ({g,f,e,d,c,b,a}), digit positions, state encoding and the
// captured-value record.
package seven_seg_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SCAN = 1'b1;

  typedef logic [1:0] dig_idx_t;
  localparam dig_idx_t DIG_ONE  = 2'd0;
  localparam dig_idx_t DIG_TEN  = 2'd1;
  localparam dig_idx_t DIG_HUN  = 2'd2;
  localparam dig_idx_t DIG_SIGN = 2'd3;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One captured display value: sign plus three BCD digits.
  typedef struct packed {
    logic       neg;
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
  } disp_t;

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Value/strobe inputs and display outputs of the scanner.
// master = value producer / display observer, slave = scanner.
interface seven_segment_scanner_if;
  logic       load;
  logic       negative;
  logic [3:0] hundred;
  logic [3:0] ten;
  logic [3:0] one;
  logic [6:0] segments;
  logic [3:0] anode;
  logic       frame_done;

  modport master (output load, negative, hundred, ten, one,
                  input  segments, anode, frame_done);
  modport slave  (input  load, negative, hundred, ten, one,
                  output segments, anode, frame_done);
endinterface

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD digit to active-high segment pattern; codes above 9 show 'E'.
module bcd_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Standard digit table, anything out of range flagged as 'E'
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed seven-segment driver. Values captured on load are
// double-buffered and only reach the display at frame boundaries.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundred/ten digits.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic clock,
  input logic reset,
  seven_segment_scanner_if.slave bus
);

  localparam int              CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dig_idx_t         idx_q, idx_d;
  disp_t            disp_q, disp_d, shad_q, shad_d, in_w;
  logic             pend_q, pend_d;
  logic [6:0]       seg_q, seg_d, pat, dec_pat;
  logic [3:0]       an_q, an_d, an_act, dig_val;
  logic             fd_q, tick, frame_b, blank;

  assign in_w    = '{neg: bus.negative, hun: bus.hundred, ten: bus.ten, one: bus.one};
  assign tick    = (cnt_q == CNT_MAX);
  assign frame_b = (state_q == ST_SCAN) && tick && (idx_q == DIG_SIGN);

  // Scan control and double-buffer update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    shad_d  = shad_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = DIG_ONE;
        if (bus.load) begin
          disp_d  = in_w;
          state_d = ST_SCAN;
        end
      end
      default: begin
        if (tick) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A load landing on the boundary bypasses the stale shadow copy
        if (frame_b && bus.load) begin
          disp_d = in_w;
          pend_d = 1'b0;
        end else if (frame_b && pend_q) begin
          disp_d = shad_q;
          pend_d = 1'b0;
        end else if (bus.load) begin
          shad_d = in_w;
          pend_d = 1'b1;
        end
      end
    endcase
  end

  bcd_to_seven_seg u_dec (.bcd_i(dig_val), .seg_o(dec_pat));

  // Digit select, blanking and polarity for the registered outputs
  always_comb begin
    case (idx_q)
      DIG_ONE: dig_val = disp_q.one;
      DIG_TEN: dig_val = disp_q.ten;
      DIG_HUN: dig_val = disp_q.hun;
      default: dig_val = 4'd0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      DIG_HUN: blank = (disp_q.hun == 4'd0);
      DIG_TEN: blank = (disp_q.hun == 4'd0) && (disp_q.ten == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    if (idx_q == DIG_SIGN) pat = disp_q.neg ? SEG_MINUS : SEG_BLANK;
    else if (blank)        pat = SEG_BLANK;
    else                   pat = dec_pat;
    an_act = 4'b0001 << idx_q;
    if (state_q != ST_SCAN) begin
      pat    = SEG_BLANK;
      an_act = 4'b0000;
    end
    seg_d = pat ^ {7{ACTIVE_LOW}};
    an_d  = an_act ^ {4{ACTIVE_LOW}};
  end

  // State, buffers and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= DIG_ONE;
      disp_q  <= '0;
      shad_q  <= '0;
      pend_q  <= 1'b0;
      seg_q   <= {7{ACTIVE_LOW}};
      an_q    <= {4{ACTIVE_LOW}};
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      shad_q  <= shad_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= frame_b;
    end
  end

  assign bus.segments   = seg_q;
  assign bus.anode      = an_q;
  assign bus.frame_done = fd_q;

endmodule
